// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: FSM state encoding,
// AHB transfer-type encodings and AHB response codes.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_timeout_wdt.sv
// APB wait-state watchdog. Counts ACCESS cycles with PREADY low and flags a
// timeout on the cycle that would bring the count up to LIMIT.
module apb_timeout_wdt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic wait_cycle,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // Wait-state counter: cleared as the bridge enters ACCESS, bumped per stall.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (start) begin
      count <= 8'd0;
    end else if (wait_cycle) begin
      count <= count + 8'd1;
    end
  end

  assign timeout = wait_cycle && (count == LAST);

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge with a SETUP/ACCESS state machine,
// two-cycle AHB ERROR on PSLVERR and back-to-back transfer support.
// Optional APB wait-state watchdog is compiled in with macro APB_TIMEOUT_EN.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int DEC_LSB        = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // AHB-Lite slave side
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  // APB master side
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  DEC_BITS,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  state_e state;
  logic   accept;
  logic   timeout;

  assign accept = HSEL && HREADY && is_active(HTRANS);

  // Data paths pass straight through; AHB holds HWDATA while HREADYOUT is low.
  assign PWDATA   = HWDATA;
  assign HRDATA   = PRDATA;
  assign DEC_BITS = PADDR[DEC_LSB+3:DEC_LSB];

`ifdef APB_TIMEOUT_EN
  apb_timeout_wdt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .start     (state == ST_SETUP),
    .wait_cycle((state == ST_ACCESS) && !PREADY),
    .timeout   (timeout)
  );

  logic unused_inputs;
  assign unused_inputs = ^HSIZE;
`else
  // Without the watchdog ACCESS waits on PREADY forever.
  assign timeout = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, 8'(TIMEOUT_CYCLES)};
`endif

  // Bridge FSM with registered APB controls, address/direction and HRESP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= 32'd0;
      PWRITE  <= 1'b0;
      HRESP   <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            state   <= ST_SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= HADDR;
            PWRITE  <= HWRITE;
          end else begin
            state   <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
          HRESP <= HRESP_OKAY;
        end

        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end

        ST_ACCESS: begin
          if (PREADY && PSLVERR) begin
            state   <= ST_ERR1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            HRESP   <= HRESP_ERROR;
          end else if (PREADY) begin
            // Completion edge doubles as the next address phase.
            if (accept) begin
              state   <= ST_SETUP;
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= HADDR;
              PWRITE  <= HWRITE;
            end else begin
              state   <= ST_IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end else if (timeout) begin
            state   <= ST_ERR1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            HRESP   <= HRESP_ERROR;
          end
        end

        ST_ERR1: begin
          state <= ST_ERR2;
          HRESP <= HRESP_ERROR;
        end

        default: begin
          state   <= ST_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          HRESP   <= HRESP_OKAY;
        end
      endcase
    end
  end

  // HREADYOUT follows PREADY in ACCESS so zero-wait completions need no extra cycle.
  // NOTE: the default assignment first guarantees no latch for unlisted states.
  always_comb begin
    HREADYOUT = 1'b1;
    case (state)
      ST_SETUP, ST_ERR1: HREADYOUT = 1'b0;
      ST_ACCESS:         HREADYOUT = PREADY && !PSLVERR;
      default:           HREADYOUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge. Inputs are driven 1 ns
// after each rising edge and outputs are checked 1 ns later.
module tb_ahb_apb_bridge;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  dec_bits;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  ahb_apb_bridge #(
    .DEC_LSB       (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK     (hclk),
    .HRESETn  (hresetn),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HTRANS   (htrans),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HREADY   (hready),
    .HWDATA   (hwdata),
    .HREADYOUT(hreadyout),
    .HRDATA   (hrdata),
    .HRESP    (hresp),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PADDR    (paddr),
    .PWRITE   (pwrite),
    .PWDATA   (pwdata),
    .DEC_BITS (dec_bits),
    .PREADY   (pready),
    .PRDATA   (prdata),
    .PSLVERR  (pslverr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic wr);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
  endtask

  task automatic end_addr_phase();
    htrans = 2'b00;
    hsel   = 1'b0;
  endtask

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = 32'd0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    hready  = 1'b1;
    hwdata  = 32'd0;
    pready  = 1'b1;
    prdata  = 32'd0;
    pslverr = 1'b0;

    // Reset values
    #3;
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_penable",   32'(penable),   32'd0);
    check("rst_paddr",     paddr,          32'd0);
    check("rst_pwrite",    32'(pwrite),    32'd0);
    check("rst_dec_bits",  32'(dec_bits),  32'd0);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp",     32'(hresp),     32'd0);
    next_cycle();
    next_cycle();
    hresetn = 1'b1;

    // Ignored requests: BUSY, and NONSEQ while HREADY is low
    next_cycle();
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h4003_0010;
    next_cycle();
    settle();
    check("busy_ignored_psel", 32'(psel), 32'd0);
    check("busy_idle_ready",   32'(hreadyout), 32'd1);
    htrans = 2'b10; hready = 1'b0;
    next_cycle();
    settle();
    check("hready_low_ignored", 32'(psel), 32'd0);
    hready = 1'b1; end_addr_phase();

    // Zero-wait write
    next_cycle();
    start_xfer(32'h4003_0010, 1'b1);
    settle();
    check("wr_idle_ready", 32'(hreadyout), 32'd1);
    next_cycle();
    end_addr_phase();
    hwdata = 32'hDEAD_BEEF;
    settle();
    check("wr_setup_psel",    32'(psel),      32'd1);
    check("wr_setup_penable", 32'(penable),   32'd0);
    check("wr_setup_paddr",   paddr,          32'h4003_0010);
    check("wr_setup_dec",     32'(dec_bits),  32'd3);
    check("wr_setup_pwrite",  32'(pwrite),    32'd1);
    check("wr_setup_ready",   32'(hreadyout), 32'd0);
    next_cycle();
    settle();
    check("wr_access_penable", 32'(penable),   32'd1);
    check("wr_access_pwdata",  pwdata,         32'hDEAD_BEEF);
    check("wr_access_ready",   32'(hreadyout), 32'd1);
    check("wr_access_paddr",   paddr,          32'h4003_0010);
    next_cycle();
    settle();
    check("wr_done_psel",  32'(psel),      32'd0);
    check("wr_done_ready", 32'(hreadyout), 32'd1);

    // Read with three wait states
    start_xfer(32'h4005_0020, 1'b0);
    pready = 1'b0;
    prdata = 32'h1234_5678;
    next_cycle();
    end_addr_phase();
    settle();
    check("rd_wait_ready_setup", 32'(hreadyout), 32'd0);
    next_cycle();
    settle();
    check("rd_wait_ready_w1", 32'(hreadyout), 32'd0);
    check("rd_wait_penable",  32'(penable),   32'd1);
    next_cycle();
    settle();
    check("rd_wait_ready_w2", 32'(hreadyout), 32'd0);
    next_cycle();
    settle();
    check("rd_wait_ready_w3", 32'(hreadyout), 32'd0);
    check("rd_wait_paddr",    paddr,          32'h4005_0020);
    next_cycle();
    pready = 1'b1;
    settle();
    check("rd_done_ready",  32'(hreadyout), 32'd1);
    check("rd_done_hrdata", hrdata,         32'h1234_5678);
    check("rd_done_pwrite", 32'(pwrite),    32'd0);
    next_cycle();
    settle();
    check("rd_idle_psel", 32'(psel), 32'd0);

    // Slave error
    start_xfer(32'h4006_0000, 1'b1);
    pslverr = 1'b1;
    next_cycle();
    end_addr_phase();
    next_cycle();
    settle();
    check("err_access_ready", 32'(hreadyout), 32'd0);
    check("err_access_hresp", 32'(hresp),     32'd0);
    next_cycle();
    settle();
    check("err1_ready", 32'(hreadyout), 32'd0);
    check("err1_hresp", 32'(hresp),     32'd1);
    check("err1_psel",  32'(psel),      32'd0);
    pslverr = 1'b0;
    next_cycle();
    settle();
    check("err2_ready", 32'(hreadyout), 32'd1);
    check("err2_hresp", 32'(hresp),     32'd1);
    next_cycle();
    settle();
    check("err_idle_ready", 32'(hreadyout), 32'd1);
    check("err_idle_hresp", 32'(hresp),     32'd0);

    // Back-to-back reads
    start_xfer(32'h4001_0000, 1'b0);
    prdata = 32'hA5A5_0001;
    next_cycle();
    settle();
    check("b2b_setup1_dec", 32'(dec_bits), 32'd1);
    htrans = 2'b11;
    haddr  = 32'h4002_0004;
    next_cycle();
    settle();
    check("b2b_access1_penable", 32'(penable),   32'd1);
    check("b2b_access1_ready",   32'(hreadyout), 32'd1);
    check("b2b_access1_dec",     32'(dec_bits),  32'd1);
    next_cycle();
    end_addr_phase();
    settle();
    check("b2b_setup2_psel",    32'(psel),    32'd1);
    check("b2b_setup2_penable", 32'(penable), 32'd0);
    check("b2b_setup2_dec",     32'(dec_bits), 32'd2);
    check("b2b_setup2_paddr",   paddr,        32'h4002_0004);
    next_cycle();
    settle();
    check("b2b_access2_ready", 32'(hreadyout), 32'd1);
    next_cycle();
    settle();
    check("b2b_idle_psel", 32'(psel), 32'd0);

    // Stuck PREADY
    start_xfer(32'h4007_0000, 1'b0);
    pready = 1'b0;
    next_cycle();
    end_addr_phase();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      settle();
      check($sformatf("stall_access_%0d", i), 32'(penable), 32'd1);
    end
`ifdef APB_TIMEOUT_EN
    next_cycle();
    settle();
    check("tmo_err1_psel",  32'(psel),      32'd0);
    check("tmo_err1_ready", 32'(hreadyout), 32'd0);
    check("tmo_err1_hresp", 32'(hresp),     32'd1);
    next_cycle();
    settle();
    check("tmo_err2_ready", 32'(hreadyout), 32'd1);
    check("tmo_err2_hresp", 32'(hresp),     32'd1);
    pready = 1'b1;
    next_cycle();
    settle();
    check("tmo_idle_hresp", 32'(hresp), 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      settle();
      check($sformatf("no_tmo_wait_%0d", i), 32'(hreadyout), 32'd0);
    end
    check("no_tmo_psel", 32'(psel), 32'd1);
    next_cycle();
    pready = 1'b1;
    settle();
    check("no_tmo_done_ready", 32'(hreadyout), 32'd1);
    next_cycle();
`endif

    // Reset asserted mid-ACCESS
    start_xfer(32'h4008_0000, 1'b1);
    pready = 1'b0;
    next_cycle();
    end_addr_phase();
    next_cycle();
    settle();
    check("mid_rst_pre_penable", 32'(penable), 32'd1);
    hresetn = 1'b0;
    settle();
    check("mid_rst_psel",    32'(psel),      32'd0);
    check("mid_rst_penable", 32'(penable),   32'd0);
    check("mid_rst_ready",   32'(hreadyout), 32'd1);
    check("mid_rst_paddr",   paddr,          32'd0);
    next_cycle();
    hresetn = 1'b1;
    pready  = 1'b1;
    next_cycle();
    start_xfer(32'h4009_0000, 1'b0);
    next_cycle();
    end_addr_phase();
    settle();
    check("post_rst_setup_psel",    32'(psel),     32'd1);
    check("post_rst_setup_penable", 32'(penable),  32'd0);
    check("post_rst_setup_dec",     32'(dec_bits), 32'd9);
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
